rv_div_seq: RTL

- Multi-cycle iterative divider for RV32M DIV/DIVU/REM/REMU.
- Sits at the consumer side of the ALU1 stage: takes op1/op2 and funct3 from that stage and produces the result.
- Drives the stall back into ALU1 and earlier stages until the result is ready.
- Radix-2 restoring division over magnitudes, with sign fix-up and RISC-V special-case results.

---
 rtl/rv_div_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rv_div_seq.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider: 34 cycles normal, 2 for div-by-zero/overflow.
// Backpressure: o_stall holds upstream while a start is pending in IDLE and throughout CALC.
module rv_div_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic            sel_rem;

  logic            is_signed;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            ovf;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            trial_ok;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic            unused_funct3_b2;

  // funct3[2] only distinguishes the M-extension group upstream
  assign unused_funct3_b2 = i_funct3[2];

  assign is_signed = ~i_funct3[0];
  assign abs1      = (is_signed && i_op1[XLEN-1]) ? -i_op1 : i_op1;
  assign abs2      = (is_signed && i_op2[XLEN-1]) ? -i_op2 : i_op2;
  assign div_zero  = (i_op2 == '0);
  assign ovf       = is_signed && (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);

  // One restoring step; trial sign bit decides the quotient bit
  assign rem_sh   = {rem, quo[XLEN-1]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign trial_ok = ~trial[XLEN];
  assign rem_nx   = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo[XLEN-2:0], trial_ok};
  assign q_fix    = neg_q ? -quo_nx : quo_nx;
  assign r_fix    = neg_r ? -rem_nx : rem_nx;

  assign o_stall = (state == CALC) || ((state == IDLE) && i_start);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_rem  <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_start) begin
            sel_rem <= i_funct3[1];
            dvs     <= abs2;
            neg_q   <= is_signed && (i_op1[XLEN-1] ^ i_op2[XLEN-1]);
            neg_r   <= is_signed && i_op1[XLEN-1];
            // Special cases are already architecturally final: no fix-up
            if (div_zero) begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= i_funct3[1] ? i_op1 : '1;
            end else if (ovf) begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= i_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
              state <= CALC;
              cnt   <= CW'(XLEN - 1);
              rem   <= '0;
              quo   <= abs1;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state    <= DONE;
            o_valid  <= 1'b1;
            o_result <= sel_rem ? r_fix : q_fix;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
